// File: rtl/period_meter.sv
// period_meter: averaged event-to-event period measurement with lock/overflow.
// Optional glitch rejection below MIN_PER clocks: define PERIOD_METER_GLITCH_EN.
`timescale 1ns/1ps

module period_meter #(
  parameter int CNT_W    = 16,
  parameter int AVG_LOG2 = 2,
  parameter int MIN_PER  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flag,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             ovf
);

  localparam int AW   = CNT_W + AVG_LOG2;
  localparam int IW   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int NAVG = 1 << AVG_LOG2;

`ifdef PERIOD_METER_GLITCH_EN
  localparam int MIN_CMP = MIN_PER;
`else
  // Counter is always >= 1 in MEAS, so every event passes.
  localparam int MIN_CMP = 1;
`endif

  localparam logic [IW-1:0]    IDX_LAST = IW'(NAVG - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MIN  = CNT_W'(MIN_CMP);

  typedef enum logic {
    SEEK,
    MEAS
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             flag_q;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             ovf_q, ovf_d;

  logic          ev;
  logic          accept;
  logic [AW-1:0] sum;

  assign ev     = flag & ~flag_q;
  assign accept = (cnt_q >= CNT_MIN);
  assign sum    = acc_q + AW'(cnt_q);

  // Next-state: seek first event, then count, accumulate and average.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    period_d = period_q;
    valid_d  = 1'b0;
    locked_d = locked_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      SEEK: begin
        if (ev) begin
          cnt_d   = CNT_ONE;
          acc_d   = '0;
          idx_d   = '0;
          state_d = MEAS;
        end
      end
      MEAS: begin
        if (cnt_q == '1) begin
          ovf_d    = 1'b1;
          locked_d = 1'b0;
          acc_d    = '0;
          idx_d    = '0;
          state_d  = SEEK;
        end else if (ev && accept) begin
          cnt_d = CNT_ONE;
          if (idx_q == IDX_LAST) begin
            period_d = CNT_W'(sum >> AVG_LOG2);
            valid_d  = 1'b1;
            locked_d = 1'b1;
            ovf_d    = 1'b0;
            acc_d    = '0;
            idx_d    = '0;
          end else begin
            acc_d = sum;
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = SEEK;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= SEEK;
      cnt_q    <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      flag_q   <= 1'b0;
      period_q <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      flag_q   <= flag;
      period_q <= period_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      ovf_q    <= ovf_d;
    end
  end

  assign period       = period_q;
  assign period_valid = valid_q;
  assign locked       = locked_q;
  assign ovf          = ovf_q;

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: directed scoreboard bench for period_meter.
// u0 uses defaults, u1 uses CNT_W=8 for the saturation case.
`timescale 1ns/1ps

module tb_period_meter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flag0 = 1'b0;
  logic        flag1 = 1'b0;
  logic [15:0] per0;
  logic [7:0]  per1;
  logic        v0, v1, l0, l1, o0, o1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ev_cyc = 0;
  int e5 = 0;

  typedef struct {
    logic [31:0] p;
    logic        l;
    logic        o;
    int          c;
  } obs_t;

  obs_t obs0[$];
  obs_t obs1[$];
  int   exp0[$];
  int   exp1[$];

  period_meter u0 (
    .clk(clk), .reset(reset), .flag(flag0),
    .period(per0), .period_valid(v0),
    .locked(l0), .ovf(o0)
  );

  period_meter #(.CNT_W(8)) u1 (
    .clk(clk), .reset(reset), .flag(flag1),
    .period(per1), .period_valid(v1),
    .locked(l1), .ovf(o1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (v0) obs0.push_back('{32'(per0), l0, o0, cyc});
    if (v1) obs1.push_back('{32'(per1), l1, o1, cyc});
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse(input int which, input int per, input int hi);
    for (int i = 0; i < per; i++) begin
      @(negedge clk);
      if (i == 0) ev_cyc = cyc;
      if (which == 0) flag0 = (i < hi);
      else flag1 = (i < hi);
    end
  endtask

  task automatic idle(input int n);
    flag0 = 1'b0;
    flag1 = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    flag0 = 1'b0;
    flag1 = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic drain(input int which, input string tag);
    obs_t o;
    int   e;
    if (which == 0) begin
      chk({tag, " strobes"}, obs0.size(), exp0.size());
      while (obs0.size() > 0 && exp0.size() > 0) begin
        o = obs0.pop_front();
        e = exp0.pop_front();
        chk({tag, " period"}, o.p, e);
        chk({tag, " locked"}, 32'(o.l), 1);
        chk({tag, " ovf"}, 32'(o.o), 0);
      end
      obs0.delete();
      exp0.delete();
    end else begin
      chk({tag, " strobes"}, obs1.size(), exp1.size());
      while (obs1.size() > 0 && exp1.size() > 0) begin
        o = obs1.pop_front();
        e = exp1.pop_front();
        chk({tag, " period"}, o.p, e);
        chk({tag, " locked"}, 32'(o.l), 1);
        chk({tag, " ovf"}, 32'(o.o), 0);
      end
      obs1.delete();
      exp1.delete();
    end
  endtask

  initial begin
    // asynchronous reset before any clock edge
    #1 reset = 1'b0;
    #1;
    chk("rst period", 32'(per0), 0);
    chk("rst valid", 32'(v0), 0);
    chk("rst locked", 32'(l0), 0);
    chk("rst ovf", 32'(o0), 0);
    chk("rst ovf u1", 32'(o1), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // 100-clock pulses: first strobe one clock after 5th event
    exp0.push_back(100);
    exp0.push_back(100);
    repeat (5) pulse(0, 100, 1);
    e5 = ev_cyc;
    repeat (4) pulse(0, 100, 1);
    idle(3);
    chk("r025 n", obs0.size(), 2);
    if (obs0.size() == 2) begin
      chk("r025 latency", obs0[0].c, e5 + 1);
      chk("r025 spacing", obs0[1].c - obs0[0].c, 400);
    end
    chk("r025 locked", 32'(l0), 1);
    chk("r025 valid low", 32'(v0), 0);
    drain(0, "r025");

    // truncating average
    do_reset();
    exp0.push_back(101);
    pulse(0, 101, 1);
    pulse(0, 102, 1);
    pulse(0, 101, 1);
    pulse(0, 102, 1);
    pulse(0, 5, 1);
    idle(3);
    drain(0, "r030");

    // extra pulse 3 clocks after each crossing
    do_reset();
`ifdef PERIOD_METER_GLITCH_EN
    exp0.push_back(100);
`else
    exp0.push_back(50);
    exp0.push_back(50);
`endif
    repeat (4) begin
      pulse(0, 3, 1);
      pulse(0, 97, 1);
    end
    pulse(0, 5, 1);
    idle(3);
    drain(0, "r027");

    // wide flag: one event per rising edge
    do_reset();
    exp0.push_back(100);
    repeat (5) pulse(0, 100, 20);
    drain(0, "r028");

    // reset mid-measurement discards partial data
    repeat (2) pulse(0, 100, 1);
    idle(30);
    chk("r029 pre period", 32'(per0), 100);
    chk("r029 pre locked", 32'(l0), 1);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("r029 period", 32'(per0), 0);
    chk("r029 valid", 32'(v0), 0);
    chk("r029 locked", 32'(l0), 0);
    chk("r029 ovf", 32'(o0), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    exp0.push_back(60);
    repeat (4) pulse(0, 60, 1);
    chk("r029 early", obs0.size(), 0);
    pulse(0, 60, 1);
    idle(3);
    drain(0, "r029");

    // CNT_W=8: lock, saturate, relock
    do_reset();
    exp1.push_back(40);
    repeat (5) pulse(1, 40, 1);
    drain(1, "r026 pre");
    pulse(1, 300, 1);
    chk("r026 ovf", 32'(o1), 1);
    chk("r026 locked", 32'(l1), 0);
    chk("r026 hold", 32'(per1), 40);
    chk("r026 nostrobe", obs1.size(), 0);
    exp1.push_back(50);
    repeat (4) pulse(1, 50, 1);
    chk("r026 sticky", 32'(o1), 1);
    pulse(1, 50, 1);
    idle(3);
    drain(1, "r026");
    chk("r026 ovf clr", 32'(o1), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
